// File: rtl/abus_mem_target.sv
// abus target: single-port word memory answering req/ack transactions after WAIT_STATES cycles.
// Build option ABUS_RANGE_ERR_EN: addresses >= DEPTH report err instead of wrapping.
module abus_mem_target #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                go_resp_s;
  logic                acc_we_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [DATA_W-1:0]   acc_wdata_s;
  logic [NB-1:0]       acc_be_s;
  logic [IDX_W-1:0]    acc_idx_s;
  logic                in_range_s;
  logic                commit_s;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state logic and request capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    go_resp_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d   = RESP;
            go_resp_s = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d   = RESP;
          go_resp_s = 1'b1;
          cnt_d     = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero wait states commit on the accepting edge, so the live bus fields are used then
  always_comb begin
    if (state_q == IDLE) begin
      acc_we_s    = we;
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
      acc_be_s    = be;
    end else begin
      acc_we_s    = we_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      acc_be_s    = be_q;
    end
    acc_idx_s = IDX_W'(32'(acc_addr_s) % 32'(DEPTH));
`ifdef ABUS_RANGE_ERR_EN
    in_range_s = (32'(acc_addr_s) < 32'(DEPTH));
`else
    in_range_s = 1'b1;
`endif
    commit_s = go_resp_s & acc_we_s & in_range_s & rst_n;
  end

  // Response outputs, all loaded on the edge entering RESP
  always_comb begin
    ack_d  = go_resp_s;
    err_d  = go_resp_s & ~in_range_s;
    busy_d = (state_d != IDLE);
    if (go_resp_s && !acc_we_s) begin
      if (in_range_s) begin
        rdata_d = mem[acc_idx_s];
      end else begin
        rdata_d = {DATA_W{1'b0}};
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      be_q    <= {NB{1'b0}};
      ack_q   <= 1'b0;
      rdata_q <= {DATA_W{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Byte-masked memory write; the array itself is never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (commit_s && acc_be_s[i]) begin
        mem[acc_idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_abus_mem_target.sv
// Bench for abus_mem_target: instance 0 has WAIT_STATES=0, instance 1 has WAIT_STATES=1.
// A reference memory model pushes expected responses to per-instance queues; acks pop them.
module tb_abus_mem_target;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NB = 2;
`ifdef ABUS_RANGE_ERR_EN
  localparam bit RANGE_ERR = 1'b1;
`else
  localparam bit RANGE_ERR = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a   [2];
  logic          we_a    [2];
  logic [AW-1:0] addr_a  [2];
  logic [DW-1:0] wdata_a [2];
  logic [NB-1:0] be_a    [2];
  logic          ack_a   [2];
  logic [DW-1:0] rdata_a [2];
  logic          err_a   [2];
  logic          busy_a  [2];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t          sb_q0 [$];
  exp_t          sb_q1 [$];
  logic [DW-1:0] model_mem [2][256];
  logic [DW-1:0] last_rd   [2];

  always #5 clk = ~clk;

  abus_mem_target #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
    .wdata(wdata_a[0]), .be(be_a[0]), .ack(ack_a[0]), .rdata(rdata_a[0]),
    .err(err_a[0]), .busy(busy_a[0])
  );

  abus_mem_target #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
    .wdata(wdata_a[1]), .be(be_a[1]), .ack(ack_a[1]), .rdata(rdata_a[1]),
    .err(err_a[1]), .busy(busy_a[1])
  );

  // Reference model: update memory, compute the expected ack-cycle response and queue it
  task automatic model_txn(input int d, input logic w, input logic [7:0] a,
                           input logic [15:0] dat, input logic [1:0] b);
    exp_t e;
    logic oor;
    int   idx;
    oor   = RANGE_ERR && (a >= 8'd128);
    idx   = int'(a) % 128;
    e.err = oor;
    if (w) begin
      if (!oor) begin
        for (int i = 0; i < NB; i++) begin
          if (b[i]) model_mem[d][idx][8*i +: 8] = dat[8*i +: 8];
        end
      end
      e.rdata = last_rd[d];
    end else begin
      e.rdata    = oor ? 16'h0000 : model_mem[d][idx];
      last_rd[d] = e.rdata;
    end
    if (d == 0) sb_q0.push_back(e);
    else        sb_q1.push_back(e);
  endtask

  task automatic pop_exp(input int d, output exp_t e, output bit ok);
    ok = 1'b1;
    if (d == 0 && sb_q0.size() > 0)      e = sb_q0.pop_front();
    else if (d == 1 && sb_q1.size() > 0) e = sb_q1.pop_front();
    else ok = 1'b0;
  endtask

  // One full transaction: drive, wait for ack (bounded), compare, release req
  task automatic run_txn(input int d, input logic w, input logic [7:0] a, input logic [15:0] dat,
                         input logic [1:0] b, input bit perturb, input string tag);
    exp_t e;
    bit   ok;
    bit   seen;
    int   lat;
    int   exp_lat;
    exp_lat = (d == 0) ? 1 : 2;
    @(negedge clk);
    req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; wdata_a[d] = dat; be_a[d] = b;
    model_txn(d, w, a, dat, b);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (ack_a[d] === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end else if (perturb && k == 1) begin
        addr_a[d]  = a ^ 8'h01;
        wdata_a[d] = ~dat;
        be_a[d]    = 2'b11;
        we_a[d]    = ~w;
      end
    end
    pop_exp(d, e, ok);
    n_checks++;
    if (!seen || !ok) begin
      n_fail++;
      $display("FAIL %s timeout: ack seen=%0b, expectation present=%0b", tag, seen, ok);
      req_a[d] = 1'b0;
      return;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, lat, exp_lat);
    end
    n_checks++;
    if (rdata_a[d] !== e.rdata) begin
      n_fail++;
      $display("FAIL %s rdata: got %h, expected %h", tag, rdata_a[d], e.rdata);
    end
    n_checks++;
    if (err_a[d] !== e.err || busy_a[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s err/busy: got %b/%b, expected %b/1", tag, err_a[d], busy_a[d], e.err);
    end
    req_a[d] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_a[d] !== 1'b0 || busy_a[d] !== 1'b0 || err_a[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after-ack: ack/busy/err got %b/%b/%b, expected 0/0/0",
               tag, ack_a[d], busy_a[d], err_a[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 8'h00; wdata_a[i] = 16'h0000; be_a[i] = 2'b00;
      last_rd[i] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (ack_a[i] !== 1'b0 || err_a[i] !== 1'b0 || busy_a[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl%0d: ack/err/busy got %b/%b/%b, expected 0/0/0",
                 i, ack_a[i], err_a[i], busy_a[i]);
      end
      n_checks++;
      if (rdata_a[i] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_rdata%0d: got %h, expected 0000", i, rdata_a[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    run_txn(1, 1'b1, 8'h05, 16'h1234, 2'b11, 1'b0, "wr05_full");
    run_txn(1, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b0, "rd05_full");
    n_checks++;
    if (rdata_a[1] !== 16'h1234) begin
      n_fail++;
      $display("FAIL rd05_const: got %h, expected 1234", rdata_a[1]);
    end
  endtask

  task automatic test_byte_enable();
    run_txn(1, 1'b1, 8'h05, 16'hABCD, 2'b01, 1'b0, "wr05_be01");
    run_txn(1, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b0, "rd05_be01");
    n_checks++;
    if (rdata_a[1] !== 16'h12CD) begin
      n_fail++;
      $display("FAIL rd05_merge: got %h, expected 12cd", rdata_a[1]);
    end
    run_txn(1, 1'b1, 8'h05, 16'hFFFF, 2'b00, 1'b0, "wr05_be00");
    run_txn(1, 1'b0, 8'h05, 16'h0000, 2'b11, 1'b0, "rd05_be00");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    run_txn(0, 1'b1, 8'h05, 16'h12CD, 2'b11, 1'b0, "b2b_wr05");
    run_txn(0, 1'b1, 8'h06, 16'h0F0F, 2'b11, 1'b0, "b2b_wr06");
    @(negedge clk);
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 8'h05; be_a[0] = 2'b00;
    model_txn(0, 1'b0, 8'h05, 16'h0000, 2'b00);
    @(negedge clk);
    pop_exp(0, e, ok);
    n_checks++;
    if (!ok || ack_a[0] !== 1'b1 || busy_a[0] !== 1'b1 || rdata_a[0] !== e.rdata) begin
      n_fail++;
      $display("FAIL b2b_first: ack/busy/rdata got %b/%b/%h, expected 1/1/%h",
               ack_a[0], busy_a[0], rdata_a[0], e.rdata);
    end
    addr_a[0] = 8'h06;
    model_txn(0, 1'b0, 8'h06, 16'h0000, 2'b00);
    @(negedge clk);
    n_checks++;
    if (ack_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: ack/busy got %b/%b, expected 0/0", ack_a[0], busy_a[0]);
    end
    @(negedge clk);
    pop_exp(0, e, ok);
    n_checks++;
    if (!ok || ack_a[0] !== 1'b1 || busy_a[0] !== 1'b1 || rdata_a[0] !== e.rdata) begin
      n_fail++;
      $display("FAIL b2b_second: ack/busy/rdata got %b/%b/%h, expected 1/1/%h",
               ack_a[0], busy_a[0], rdata_a[0], e.rdata);
    end
    n_checks++;
    if (rdata_a[0] !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL b2b_const: got %h, expected 0f0f", rdata_a[0]);
    end
    req_a[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ack_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: ack/busy got %b/%b, expected 0/0", ack_a[0], busy_a[0]);
    end
  endtask

  task automatic test_range();
    run_txn(1, 1'b0, 8'h85, 16'h0000, 2'b00, 1'b0, "rd85");
    run_txn(1, 1'b1, 8'h85, 16'hEEEE, 2'b11, 1'b0, "wr85");
    run_txn(1, 1'b0, 8'h05, 16'h0000, 2'b00, 1'b0, "rd05_after_wr85");
    run_txn(1, 1'b1, 8'h05, 16'h12CD, 2'b11, 1'b0, "wr05_restore");
  endtask

  task automatic test_capture();
    run_txn(1, 1'b1, 8'h09, 16'h1111, 2'b11, 1'b0, "cap_wr09");
    run_txn(1, 1'b1, 8'h08, 16'h3C3C, 2'b11, 1'b1, "cap_wr08");
    run_txn(1, 1'b0, 8'h08, 16'h0000, 2'b00, 1'b1, "cap_rd08");
    run_txn(1, 1'b0, 8'h09, 16'h0000, 2'b00, 1'b0, "cap_rd09");
  endtask

  task automatic test_reset_mid();
    bit pulsed;
    run_txn(1, 1'b1, 8'h07, 16'h5A5A, 2'b11, 1'b0, "mid_prewr07");
    @(negedge clk);
    req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 8'h07; wdata_a[1] = 16'hFFFF; be_a[1] = 2'b11;
    @(negedge clk);
    n_checks++;
    if (busy_a[1] !== 1'b1 || ack_a[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_access: busy/ack got %b/%b, expected 1/0", busy_a[1], ack_a[1]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_a[1] !== 1'b0 || ack_a[1] !== 1'b0 || rdata_a[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset: busy/ack/rdata got %b/%b/%h, expected 0/0/0000",
               busy_a[1], ack_a[1], rdata_a[1]);
    end
    req_a[1]   = 1'b0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    @(negedge clk);
    rst_n  = 1'b1;
    pulsed = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_a[1] !== 1'b0) pulsed = 1'b1;
    end
    n_checks++;
    if (pulsed !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_noack: ack pulsed=%b, expected 0", pulsed);
    end
    run_txn(1, 1'b0, 8'h07, 16'h0000, 2'b00, 1'b0, "mid_rd07");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_range();
    test_capture();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
